// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU opcode encodings, RV32 major
// opcodes and the decoded-operand bundle passed from decode to the register stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        illegal;
    } issue_t;

    // Shift amounts are clipped to 5 bits so the ALU never sees a shift above 31.
    function automatic logic [31:0] shamt(input logic [31:0] src);
        return {27'b0, src[4:0]};
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational decode of one instruction into ALU operands, opcode and an
// illegal flag for encodings that have no ALU mapping.
module alu_dec
    import alu_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  op,
    output logic        illegal
);

    logic [31:0] src;

    always_comb begin
        a       = '0;
        b       = '0;
        op      = ALU_ADD;
        illegal = 1'b0;
        src     = (opcode == OP) ? rs2_data : imm;
        case (opcode)
            OP, OP_IMM: begin
                a = rs1_data;
                b = src;
                case (funct3)
                    3'b000:         op = (opcode == OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        op = ALU_SLL;
                        b  = shamt(src);
                    end
                    3'b010, 3'b011: op = ALU_SLT;
                    3'b100:         op = ALU_XOR;
                    3'b101: begin
                        op = funct7_5 ? ALU_SRA : ALU_SRL;
                        b  = shamt(src);
                    end
                    3'b110:         op = ALU_OR;
                    default:        op = ALU_AND;
                endcase
            end
            LOAD, STORE: begin
                a = rs1_data;
                b = imm;
            end
            LUI:   b = imm;
            AUIPC: begin
                a = pc;
                b = imm;
            end
            BRANCH: begin
                a = rs1_data;
                b = rs2_data;
                case (funct3)
                    3'b000, 3'b001: op = ALU_SUB;
                    3'b010, 3'b011: begin
                        // No compare defined for these branch encodings.
                        a       = '0;
                        b       = '0;
                        illegal = 1'b1;
                    end
                    default:        op = ALU_SLT;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-entry valid/ready register stage between decode and execute; holds the
// decoded ALU operands until the execute stage consumes them.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    issue_t dec;

    alu_dec u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .imm      (imm),
        .pc       (pc),
        .a        (dec.a),
        .b        (dec.b),
        .op       (dec.op),
        .illegal  (dec.illegal)
    );

    assign in_ready = (!out_valid || out_ready) && !flush;

    // Data registers only load on capture, so they hold while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= ALU_AND;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            alu_a     <= dec.a;
            alu_b     <= dec.b;
            alu_op    <= dec.op;
            illegal   <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode table, hand-written stall/flush/reset
// sequences, and randomized handshake traffic against a behavioural model.
module tb_alu_issue;

    localparam logic [3:0] E_AND = 4'b0000, E_OR = 4'b0001, E_ADD = 4'b0010, E_SUB = 4'b0110;
    localparam logic [3:0] E_SLT = 4'b0111, E_XOR = 4'b1100, E_SLL = 4'b1101, E_SRL = 4'b1110;
    localparam logic [3:0] E_SRA = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, funct7_5, flush, out_valid, out_ready, illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, pc, alu_a, alu_b;
    logic [3:0]  alu_op;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1, rs2, im, p;
        logic [31:0] ea, eb;
        logic [3:0]  eop;
        logic        eill;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    vec_t tbl[$];

    // Behavioural model state: the one instruction the stage is holding.
    logic  m_valid;
    exp_t  m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic s,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [3:0] eop, input logic eill);
        vec_t v;
        v.opc = o; v.f3 = f; v.f7 = s; v.rs1 = r1; v.rs2 = r2; v.im = i; v.p = p;
        v.ea = ea; v.eb = eb; v.eop = eop; v.eill = eill;
        return v;
    endfunction

    // Reference decode written from the instruction-class rules.
    function automatic exp_t ref_dec(input logic [6:0] o, input logic [2:0] f, input logic s,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        logic [31:0] operand;
        e.a = 0; e.b = 0; e.op = E_ADD; e.ill = 1'b0;
        if (o == 7'b0110011 || o == 7'b0010011) begin
            operand = (o == 7'b0110011) ? r2 : i;
            e.a = r1;
            e.b = operand;
            if (f == 3'd1 || f == 3'd5) e.b = operand % 32;
            if (f == 3'd0) e.op = (o == 7'b0110011 && s) ? E_SUB : E_ADD;
            else if (f == 3'd1) e.op = E_SLL;
            else if (f == 3'd2 || f == 3'd3) e.op = E_SLT;
            else if (f == 3'd4) e.op = E_XOR;
            else if (f == 3'd5) e.op = s ? E_SRA : E_SRL;
            else if (f == 3'd6) e.op = E_OR;
            else e.op = E_AND;
        end else if (o == 7'b0000011 || o == 7'b0100011) begin
            e.a = r1; e.b = i;
        end else if (o == 7'b0110111) begin
            e.b = i;
        end else if (o == 7'b0010111) begin
            e.a = p; e.b = i;
        end else if (o == 7'b1100011 && f != 3'd2 && f != 3'd3) begin
            e.a = r1; e.b = r2;
            e.op = (f < 3'd2) ? E_SUB : E_SLT;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f, input logic s,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] i,
                         input logic [31:0] p);
        in_valid = v; opcode = o; funct3 = f; funct7_5 = s;
        rs1_data = r1; rs2_data = r2; imm = i; pc = p;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out.a = 0; m_out.b = 0; m_out.op = E_AND; m_out.ill = 1'b0;
    endtask

    // One randomized-phase cycle: check in_ready, clock, update model, check outputs.
    task automatic tick(input string tag);
        logic acc;
        #1;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (!m_valid || out_ready) && !flush});
        acc = in_valid && (!m_valid || out_ready) && !flush;
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_out = ref_dec(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc);
        end else if (out_ready) m_valid = 1'b0;
        #1;
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        chk({tag, ".alu_a"}, alu_a, m_out.a);
        chk({tag, ".alu_b"}, alu_b, m_out.b);
        chk({tag, ".alu_op"}, {28'b0, alu_op}, {28'b0, m_out.op});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, m_out.ill});
    endtask

    initial begin
        logic [6:0] legal_opc [7];
        legal_opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b0110111, 7'b0010111, 7'b1100011};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 1'b0, 0, 0, 0, 0);

        tbl.push_back(mk(7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 0, 0, 32'd5, 32'd7, E_ADD, 1'b0));
        tbl.push_back(mk(7'h13, 3'd5, 1'b1, 32'h8000_0000, 0, 32'h423, 0, 32'h8000_0000, 32'd3, E_SRA, 1'b0));
        tbl.push_back(mk(7'h17, 3'd0, 1'b0, 32'hdead, 0, 32'h2_0000, 32'h1000, 32'h1000, 32'h2_0000, E_ADD, 1'b0));
        tbl.push_back(mk(7'h7f, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, E_ADD, 1'b1));
        tbl.push_back(mk(7'h33, 3'd0, 1'b1, 32'd9, 32'd4, 0, 0, 32'd9, 32'd4, E_SUB, 1'b0));
        tbl.push_back(mk(7'h13, 3'd1, 1'b1, 32'd6, 0, 32'hfff, 0, 32'd6, 32'd31, E_SLL, 1'b0));
        tbl.push_back(mk(7'h33, 3'd3, 1'b0, 32'd3, 32'd8, 0, 0, 32'd3, 32'd8, E_SLT, 1'b0));
        tbl.push_back(mk(7'h13, 3'd0, 1'b1, 32'h10, 0, 32'hffff_fc00, 0, 32'h10, 32'hffff_fc00, E_ADD, 1'b0));
        tbl.push_back(mk(7'h33, 3'd5, 1'b1, 32'd1, 32'h25, 0, 0, 32'd1, 32'd5, E_SRA, 1'b0));
        tbl.push_back(mk(7'h33, 3'd5, 1'b0, 32'd2, 32'hffff_ffe3, 0, 0, 32'd2, 32'd3, E_SRL, 1'b0));
        tbl.push_back(mk(7'h13, 3'd4, 1'b0, 32'd7, 0, 32'hff, 0, 32'd7, 32'hff, E_XOR, 1'b0));
        tbl.push_back(mk(7'h33, 3'd6, 1'b0, 32'ha, 32'hb, 0, 0, 32'ha, 32'hb, E_OR, 1'b0));
        tbl.push_back(mk(7'h13, 3'd7, 1'b0, 32'hc, 0, 32'hd, 0, 32'hc, 32'hd, E_AND, 1'b0));
        tbl.push_back(mk(7'h03, 3'd2, 1'b0, 32'h100, 32'h9, 32'h8, 0, 32'h100, 32'h8, E_ADD, 1'b0));
        tbl.push_back(mk(7'h23, 3'd2, 1'b0, 32'h200, 32'h77, 32'hffff_fffc, 0, 32'h200, 32'hffff_fffc, E_ADD, 1'b0));
        tbl.push_back(mk(7'h37, 3'd0, 1'b0, 32'h55, 0, 32'h1234_5000, 0, 0, 32'h1234_5000, E_ADD, 1'b0));
        tbl.push_back(mk(7'h63, 3'd1, 1'b0, 32'd1, 32'd2, 32'h40, 0, 32'd1, 32'd2, E_SUB, 1'b0));
        tbl.push_back(mk(7'h63, 3'd6, 1'b0, 32'd3, 32'd4, 0, 0, 32'd3, 32'd4, E_SLT, 1'b0));
        tbl.push_back(mk(7'h63, 3'd2, 1'b0, 32'd5, 32'd6, 0, 0, 0, 0, E_ADD, 1'b1));
        tbl.push_back(mk(7'h63, 3'd4, 1'b0, 32'd7, 32'd8, 0, 0, 32'd7, 32'd8, E_SLT, 1'b0));

        // Reset state.
        #3;
        chk("rst.out_valid", {31'b0, out_valid}, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.alu_b", alu_b, 0);
        chk("rst.alu_op", {28'b0, alu_op}, 0);
        chk("rst.illegal", {31'b0, illegal}, 0);
        chk("rst.in_ready", {31'b0, in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, back to back with out_ready held high.
        out_ready = 1'b1;
        foreach (tbl[k]) begin
            drive(1'b1, tbl[k].opc, tbl[k].f3, tbl[k].f7, tbl[k].rs1, tbl[k].rs2, tbl[k].im, tbl[k].p);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.out_valid", k), {31'b0, out_valid}, 1);
            chk($sformatf("tbl%0d.alu_a", k), alu_a, tbl[k].ea);
            chk($sformatf("tbl%0d.alu_b", k), alu_b, tbl[k].eb);
            chk($sformatf("tbl%0d.alu_op", k), {28'b0, alu_op}, {28'b0, tbl[k].eop});
            chk($sformatf("tbl%0d.illegal", k), {31'b0, illegal}, {31'b0, tbl[k].eill});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain.out_valid", {31'b0, out_valid}, 0);

        // Stall: hold A for three cycles while B waits.
        drive(1'b1, 7'h33, 3'd0, 1'b0, 32'h11, 32'h22, 0, 0);
        @(posedge clk); #1;
        chk("stall.A_valid", {31'b0, out_valid}, 1);
        drive(1'b1, 7'h33, 3'd0, 1'b1, 32'h33, 32'h44, 0, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall.in_ready", {31'b0, in_ready}, 0);
            @(posedge clk); #1;
            chk("stall.out_valid", {31'b0, out_valid}, 1);
            chk("stall.alu_a", alu_a, 32'h11);
            chk("stall.alu_b", alu_b, 32'h22);
            chk("stall.alu_op", {28'b0, alu_op}, {28'b0, E_ADD});
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        chk("stall.B_valid", {31'b0, out_valid}, 1);
        chk("stall.B_a", alu_a, 32'h33);
        chk("stall.B_op", {28'b0, alu_op}, {28'b0, E_SUB});

        // Flush while holding B with a new instruction offered.
        out_ready = 1'b0;
        drive(1'b1, 7'h13, 3'd4, 1'b0, 32'h55, 0, 32'h66, 0);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        chk("flush.out_valid", {31'b0, out_valid}, 0);
        chk("flush.no_capture_a", alu_a, 32'h33);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush.still_empty", {31'b0, out_valid}, 0);
        chk("flush.no_capture_op", {28'b0, alu_op}, {28'b0, E_SUB});

        // Asynchronous reset while an instruction is held.
        drive(1'b1, 7'h33, 3'd4, 1'b0, 32'h77, 32'h88, 0, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("arst.pre_valid", {31'b0, out_valid}, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {31'b0, out_valid}, 0);
        chk("arst.alu_op", {28'b0, alu_op}, 0);
        chk("arst.alu_a", alu_a, 0);
        @(posedge clk); #1;
        chk("arst.no_capture_in_reset", {31'b0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.first_capture", {31'b0, out_valid}, 1);
        chk("arst.first_capture_op", {28'b0, alu_op}, {28'b0, E_XOR});

        // Randomized handshake traffic from a clean reset.
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 8) ? legal_opc[$urandom_range(0, 6)] : 7'($urandom),
                  3'($urandom), 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63)), $urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 9) == 0);
            tick("rand");
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
